pop_graph_render: RTL and testbench



---
 rtl/pop_graph_render.sv | 126 ++++++++++++
 tb/tb_pop_graph_render.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pop_graph_render.sv
// Per-frame live-cell counter with a scrolling bar-graph overlay of recent frame populations.
// History lives in a simple dual-port RAM; pixel output has a fixed two-cycle latency.
module pop_graph_render #(
  parameter int          LIFE_W      = 1024,
  parameter int          LIFE_H      = 768,
  parameter int          HIST_DEPTH  = 64,
  parameter int          BAR_W       = 4,
  parameter int          GRAPH_X     = 0,
  parameter int          GRAPH_Y     = 640,
  parameter int          GRAPH_H     = 64,
  parameter int          COUNT_W     = 20,
  parameter int          SCALE_SHIFT = 10,
  parameter logic [11:0] FG_COLOR    = 12'h0F0
) (
  input  logic               clk_130mhz,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               is_alive_in,
  output logic [11:0]        pix_out,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid_out
);

  localparam int IDX_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int FILL_W = $clog2(HIST_DEPTH + 1);
  localparam int BAR_SH = $clog2(BAR_W);
  localparam int ROW_W  = $clog2(GRAPH_H + 1);
  localparam logic [COUNT_W-1:0] ACC_MAX = '1;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == ACC_MAX) ? v : v + COUNT_W'(1);
  endfunction

  function automatic logic [ROW_W-1:0] bar_height(input logic [COUNT_W-1:0] v);
    logic [COUNT_W-1:0] s;
    s = v >> SCALE_SHIFT;
    return (s > COUNT_W'(GRAPH_H)) ? ROW_W'(GRAPH_H) : ROW_W'(s);
  endfunction

  logic [COUNT_W-1:0] acc_q, acc_d, count_q, count_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               armed_q, armed_d, cnt_vld_q;
  logic               boundary, in_life, commit;

  always_comb begin
    boundary = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    in_life  = (int'(hcount_in) < LIFE_W) && (int'(vcount_in) < LIFE_H);
    commit   = boundary && armed_q && !rst_in;
    acc_d    = acc_q;
    if (boundary) acc_d = COUNT_W'(is_alive_in);
    else if (in_life && is_alive_in) acc_d = sat_inc(acc_q);
    wr_ptr_d = commit ? wr_ptr_q + IDX_W'(1) : wr_ptr_q;
    fill_d   = (commit && fill_q != FILL_W'(HIST_DEPTH)) ? fill_q + FILL_W'(1) : fill_q;
    armed_d  = armed_q | boundary;
    count_d  = commit ? acc_q : count_q;
  end

  // The first boundary after reset only arms the counter, so a partial frame is never recorded.
  always_ff @(posedge clk_130mhz) begin
    if (rst_in) begin
      acc_q     <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      count_q   <= '0;
      cnt_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      count_q   <= count_d;
      cnt_vld_q <= commit;
    end
  end

  logic signed [31:0] hx_s, row_s, bar_s;
  logic [IDX_W-1:0]   rd_idx;
  logic               in_region, ent_ok;

  always_comb begin
    hx_s      = int'(hcount_in) - GRAPH_X;
    row_s     = GRAPH_Y + GRAPH_H - 1 - int'(vcount_in);
    bar_s     = hx_s >>> BAR_SH;
    in_region = (hx_s >= 0) && (hx_s < HIST_DEPTH * BAR_W) &&
                (int'(vcount_in) >= GRAPH_Y) && (int'(vcount_in) < GRAPH_Y + GRAPH_H);
    rd_idx    = wr_ptr_q + IDX_W'(bar_s);
    // Written entries occupy the rightmost fill_q bars; older slots still hold stale data.
    ent_ok    = bar_s >= (HIST_DEPTH - int'(fill_q));
  end

  logic [COUNT_W-1:0] hist_mem [HIST_DEPTH];
  logic [COUNT_W-1:0] rd_data_p1_q;
  logic [ROW_W-1:0]   row_p1_q;
  logic               ent_ok_p1_q, vld_p1_q;
  logic [11:0]        pix_p2_q;
  logic               lit_p1;

  // Stage 1: region decode and registered history read (old data on same-index write)
  always_ff @(posedge clk_130mhz) begin
    if (commit) hist_mem[wr_ptr_q] <= acc_q;
    rd_data_p1_q <= hist_mem[rd_idx];
    row_p1_q     <= ROW_W'(row_s);
    ent_ok_p1_q  <= ent_ok;
  end

  always_ff @(posedge clk_130mhz) begin
    if (rst_in) vld_p1_q <= 1'b0;
    else        vld_p1_q <= in_region;
  end

  // Stage 2: height compare and colour select
  always_comb lit_p1 = vld_p1_q && ent_ok_p1_q && (row_p1_q < bar_height(rd_data_p1_q));

  always_ff @(posedge clk_130mhz) begin
    if (rst_in) pix_p2_q <= 12'h000;
    else        pix_p2_q <= lit_p1 ? FG_COLOR : 12'h000;
  end

  assign pix_out         = pix_p2_q;
  assign count_out       = count_q;
  assign count_valid_out = cnt_vld_q;

endmodule

// File: tb/tb_pop_graph_render.sv
// Bench for pop_graph_render: scaled-down life area, random frames, queue-based history model.
module tb_pop_graph_render;

  localparam int LW = 16, LH = 8, D = 8, BW = 4;
  localparam int GX = 8, GY = 20, GH = 12, SS = 3;
  localparam int CWA = 20, CWB = 6;
  localparam logic [11:0] FG = 12'h0F0;

  logic           clk = 1'b0;
  logic           rst_r;
  logic [10:0]    hcount;
  logic [9:0]     vcount;
  logic           alive;
  logic [11:0]    pix_a, pix_b;
  logic [CWA-1:0] cnt_a;
  logic [CWB-1:0] cnt_b;
  logic           vld_a, vld_b;

  int errors = 0;
  int checks = 0;
  int hist[$];
  bit armed = 0;
  int pend = 0;
  int last_a = 0, last_b = 0;

  pop_graph_render #(.LIFE_W(LW), .LIFE_H(LH), .HIST_DEPTH(D), .BAR_W(BW), .GRAPH_X(GX),
    .GRAPH_Y(GY), .GRAPH_H(GH), .COUNT_W(CWA), .SCALE_SHIFT(SS), .FG_COLOR(FG)) dut_a (
    .clk_130mhz(clk), .rst_in(rst_r), .hcount_in(hcount), .vcount_in(vcount),
    .is_alive_in(alive), .pix_out(pix_a), .count_out(cnt_a), .count_valid_out(vld_a));

  pop_graph_render #(.LIFE_W(LW), .LIFE_H(LH), .HIST_DEPTH(D), .BAR_W(BW), .GRAPH_X(GX),
    .GRAPH_Y(GY), .GRAPH_H(GH), .COUNT_W(CWB), .SCALE_SHIFT(SS), .FG_COLOR(FG)) dut_b (
    .clk_130mhz(clk), .rst_in(rst_r), .hcount_in(hcount), .vcount_in(vcount),
    .is_alive_in(alive), .pix_out(pix_b), .count_out(cnt_b), .count_valid_out(vld_b));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // Oldest committed frame is leftmost; unwritten bars on the left stay dark.
  function automatic logic [11:0] exp_pix(input int h, input int v);
    int n, b, ht;
    n = hist.size();
    if (h < GX || h >= GX + D * BW || v < GY || v >= GY + GH) return 12'h000;
    b = (h - GX) / BW;
    if (b < D - n) ht = 0;
    else begin
      ht = hist[b - (D - n)] >> SS;
      if (ht > GH) ht = GH;
    end
    return ((GY + GH - 1 - v) < ht) ? FG : 12'h000;
  endfunction

  task automatic probe(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
    alive  = 1'b0;
    tick();
    tick();
    check($sformatf("pix(%0d,%0d)", h, v), {20'd0, pix_a}, {20'd0, exp_pix(h, v)});
  endtask

  // mode 0: all alive, 1: toggle per pixel starting 0, 2: random with density dens%.
  task automatic do_frame(input int mode, input int dens, input int rst_row);
    int cnt;
    bit tog, a;
    cnt = 0;
    tog = 1'b0;
    for (int v = 0; v < LH + 2; v++) begin
      for (int h = 0; h < LW + 4; h++) begin
        case (mode)
          0:       a = 1'b1;
          1:       a = tog;
          default: a = ($urandom_range(0, 99) < dens);
        endcase
        tog    = ~tog;
        hcount = 11'(h);
        vcount = 10'(v);
        alive  = a;
        rst_r  = (v == rst_row && h == 5);
        if (h < LW && v < LH && a) cnt++;
        tick();
        if (rst_r) begin
          rst_r  = 1'b0;
          armed  = 0;
          hist.delete();
          last_a = 0;
          last_b = 0;
          cnt    = 0;
          check("midrst_pix", {20'd0, pix_a}, 32'd0);
          check("midrst_cnt", cnt_a, 32'd0);
          check("midrst_vld", {31'd0, vld_a}, 32'd0);
        end else if (v == 0 && h == 0) begin
          if (armed) begin
            last_a = sat(pend, CWA);
            last_b = sat(pend, CWB);
            hist.push_back(last_a);
            if (hist.size() > D) void'(hist.pop_front());
          end
          check("strobe_a", {31'd0, vld_a}, {31'd0, armed});
          check("count_a", cnt_a, last_a);
          check("strobe_b", {31'd0, vld_b}, {31'd0, armed});
          check("count_b_sat", {26'd0, cnt_b}, last_b);
          armed = 1;
        end else if (v == 0 && h == 1) begin
          check("strobe_a_drop", {31'd0, vld_a}, 32'd0);
          check("strobe_b_drop", {31'd0, vld_b}, 32'd0);
        end
      end
    end
    pend = cnt;
  endtask

  int ex[7];
  int ey[7];

  initial begin
    rst_r  = 1'b1;
    hcount = 11'd100;
    vcount = 10'd100;
    alive  = 1'b1;
    repeat (3) tick();
    check("rst_pix", {20'd0, pix_a}, 32'd0);
    check("rst_cnt", cnt_a, 32'd0);
    check("rst_vld", {31'd0, vld_a}, 32'd0);
    rst_r = 1'b0;

    do_frame(0, 0, -1);
    do_frame(0, 0, -1);
    check("full_frame_count", cnt_a, LW * LH);
    do_frame(1, 0, -1);
    do_frame(1, 0, -1);
    check("toggle_count", cnt_a, LW * LH / 2);
    for (int i = 0; i < 8; i++) do_frame(2, $urandom_range(5, 95), -1);

    ex = '{GX, GX - 1, GX + D * BW - 1, GX + D * BW, GX + D * BW - 1, GX + D * BW - 1, GX + 2};
    ey = '{GY + GH - 1, GY + GH - 1, GY + GH - 1, GY + GH - 1, GY, GY - 1, GY + GH};
    for (int i = 0; i < 7; i++) probe(ex[i], ey[i]);
    for (int i = 0; i < 40; i++)
      probe($urandom_range(GX - 2, GX + D * BW + 2), $urandom_range(GY - 2, GY + GH + 1));

    do_frame(0, 0, 3);
    do_frame(2, 50, -1);
    do_frame(2, 20, -1);
    check("post_reset_fill", hist.size(), 1);
    for (int i = 0; i < 30; i++)
      probe($urandom_range(GX, GX + D * BW - 1), $urandom_range(GY, GY + GH - 1));
    for (int v = GY; v < GY + GH; v++) probe(GX + D * BW - 1, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
